// File: rtl/button_stepper.sv
// rtl/button_stepper.sv - debounced push-button to single-cycle step pulse with auto-repeat
// Two-flop synchronizer feeds a press/release debounce FSM; held presses may auto-repeat.
module button_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       repeat_en,
  input  logic       clr,
  output logic       step,
  output logic       pressed,
  output logic [7:0] step_count,
  output logic [2:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [31:0]   RPT_DLY = 32'(REPEAT_DELAY);
  localparam logic [31:0]   RPT_PER = 32'(REPEAT_PERIOD);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DEB = 3'd1,
    HELD      = 3'd2,
    REL_DEB   = 3'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rpt_q, rpt_d;
  logic          armed_q, armed_d;
  logic          step_q, step_d;
  logic [7:0]    count_q, count_d;

  logic          btn_s;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   rpt_inc;
  logic [31:0]   rpt_target;

  assign btn_s      = sync2_q;
  assign cnt_inc    = cnt_q + CNT_ONE;
  assign rpt_inc    = rpt_q + 32'd1;
  // Before the first repeat, wait the long delay; afterwards the shorter period.
  assign rpt_target = armed_q ? RPT_PER : RPT_DLY;

  always_comb begin
    state_d = state_q;
    sync1_d = btn;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    armed_d = armed_q;
    step_d  = 1'b0;
    count_d = count_q;

    if (clr) begin
      count_d = 8'd0;
    end else if (step_q) begin
      count_d = count_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        rpt_d   = '0;
        armed_d = 1'b0;
        if (btn_s) begin
          state_d = PRESS_DEB;
        end
      end
      PRESS_DEB: begin
        rpt_d   = '0;
        armed_d = 1'b0;
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == DB_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!btn_s) begin
          state_d = REL_DEB;
          rpt_d   = '0;
          armed_d = 1'b0;
        end else if (!repeat_en) begin
          rpt_d   = '0;
          armed_d = 1'b0;
        end else if (rpt_inc >= rpt_target) begin
          // A due repeat that would abut the previous pulse slips by one cycle.
          if (!step_q) begin
            step_d  = 1'b1;
            rpt_d   = '0;
            armed_d = 1'b1;
          end
        end else begin
          rpt_d = rpt_inc;
        end
      end
      REL_DEB: begin
        rpt_d   = '0;
        armed_d = 1'b0;
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc == DB_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rpt_d   = '0;
        armed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      rpt_q   <= '0;
      armed_q <= 1'b0;
      step_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      armed_q <= armed_d;
      step_q  <= step_d;
      count_q <= count_d;
    end
  end

  assign step       = step_q;
  assign pressed    = (state_q == HELD) || (state_q == REL_DEB);
  assign step_count = count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_button_stepper.sv
// tb/tb_button_stepper.sv - directed scoreboard bench for button_stepper
module tb_button_stepper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       repeat_en = 1'b0;
  logic       clr = 1'b0;
  logic       step;
  logic       pressed;
  logic [7:0] step_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int t0;
  int exp_q[$];
  int seen_q[$];
  bit dbl = 1'b0;
  logic prev_step = 1'b0;

  button_stepper #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .repeat_en(repeat_en),
    .clr(clr),
    .step(step),
    .pressed(pressed),
    .step_count(step_count),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Step pulses are recorded with the number of the edge that raised them.
  always @(negedge clk) begin
    if (step === 1'b1) seen_q.push_back(cyc);
    if (step === 1'b1 && prev_step === 1'b1) dbl = 1'b1;
    prev_step = step;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    int e;
    int s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (seen_q.size() == 0) begin
        check({tag, "_missing_step"}, 32'hFFFF_FFFF, e);
      end else begin
        s = seen_q.pop_front();
        check({tag, "_step_cycle"}, s, e);
      end
    end
    check({tag, "_extra_steps"}, seen_q.size(), 0);
    seen_q.delete();
  endtask

  task automatic press_start();
    btn = 1'b1;
    t0 = cyc + 1;
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_state", state, 0);
    check("reset_step", step, 0);
    check("reset_pressed", pressed, 0);
    check("reset_count", step_count, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Clean press
    press_start();
    exp_q.push_back(t0 + 6);
    tick(2);
    check("clean_t0p1_state", state, 0);
    tick(1);
    check("clean_t0p2_state", state, 1);
    tick(3);
    check("clean_t0p5_step", step, 0);
    tick(1);
    check("clean_t0p6_state", state, 2);
    check("clean_t0p6_step", step, 1);
    check("clean_t0p6_pressed", pressed, 1);
    tick(1);
    check("clean_after_step", step, 0);
    check("clean_count", step_count, 1);
    btn = 1'b0;
    tick(12);
    check("clean_release_state", state, 0);
    drain("clean");

    // Bouncing press, then short release bounce
    for (int i = 0; i < 4; i++) begin
      btn = ~btn;
      tick(2);
    end
    press_start();
    exp_q.push_back(t0 + 6);
    tick(9);
    check("bounce_count", step_count, 2);
    btn = 1'b0;
    tick(2);
    btn = 1'b1;
    tick(8);
    check("relbounce_state", state, 2);
    check("relbounce_count", step_count, 2);
    btn = 1'b0;
    tick(12);
    check("bounce_idle", state, 0);
    drain("bounce");

    // Auto-repeat enabled
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_count", step_count, 0);
    repeat_en = 1'b1;
    press_start();
    foreach (exp_q[i]) ;
    exp_q.push_back(t0 + 6);
    exp_q.push_back(t0 + 26);
    exp_q.push_back(t0 + 34);
    exp_q.push_back(t0 + 42);
    exp_q.push_back(t0 + 50);
    tick(54);
    btn = 1'b0;
    tick(12);
    check("repeat_on_count", step_count, 5);
    drain("repeat_on");

    // Same hold with auto-repeat disabled
    repeat_en = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    press_start();
    exp_q.push_back(t0 + 6);
    tick(54);
    btn = 1'b0;
    tick(12);
    check("repeat_off_count", step_count, 1);
    drain("repeat_off");

    // Wrap after 256 presses
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("wrap_count_255", step_count, 255);
      press_start();
      exp_q.push_back(t0 + 6);
      tick(8);
      btn = 1'b0;
      tick(8);
    end
    check("wrap_count_0", step_count, 0);
    drain("wrap");

    // Clear coincident with a step pulse
    press_start();
    exp_q.push_back(t0 + 6);
    tick(7);
    check("clr_coincide_step", step, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_coincide_count", step_count, 0);
    btn = 1'b0;
    tick(12);
    drain("clr_coincide");

    // Reset during PRESS_DEB, button held through reset
    btn = 1'b1;
    tick(4);
    check("mid_press_state", state, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_press_state", state, 0);
    tick(2);
    rst = 1'b0;
    t0 = cyc + 1;
    exp_q.push_back(t0 + 6);
    tick(7);
    check("post_rst_step", step, 1);
    tick(3);
    check("mid_hold_state", state, 2);
    #2 rst = 1'b1;
    #1;
    check("rst_hold_state", state, 0);
    check("rst_hold_pressed", pressed, 0);
    check("rst_hold_count", step_count, 0);
    tick(2);
    rst = 1'b0;
    t0 = cyc + 1;
    exp_q.push_back(t0 + 6);
    tick(10);
    check("post_rst2_count", step_count, 1);
    btn = 1'b0;
    tick(12);
    drain("reset");

    check("no_consecutive_steps", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
